// File: rtl/muldiv_pkg.sv
// muldiv_pkg: FSM state encoding and RV M-extension func3 codes shared by the muldiv unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-divide iteration on unsigned magnitudes.
module div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem_cur,
  input  logic         shift_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // rem_cur < divisor, so the borrow bit alone decides whether the subtract fits.
  always_comb begin
    shifted  = {rem_cur, shift_bit};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[W];
    rem_next = q_bit ? diff[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV64 M-extension multiply/divide, radix-2 iterative via IDLE/PREP/CALC/FIX/DONE.
// Optional macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle multiplier (PREP -> DONE).
// Handshake: i_start is accepted only while o_busy is low (IDLE or DONE) and i_kill is low;
// o_done pulses for one cycle with o_result/o_rd_addr, which then hold until the next o_done.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_srst,
  input  logic                  i_start,
  input  logic [2:0]            i_func3,
  input  logic                  i_word,
  input  logic [DATA_WIDTH-1:0] i_src_1,
  input  logic [DATA_WIDTH-1:0] i_src_2,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic                  i_kill,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [REG_ADDR_W-1:0] o_rd_addr
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  state_e                state, state_nxt;
  logic [CW-1:0]         cnt, last_cnt;
  logic [2:0]            op_q;
  logic                  word_q, neg_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [W-1:0]          src1_q, src2_q, mpl_q, rem_q, quo_q, dsr_q;
  logic [2*W-1:0]        acc_q, mcd_q;

  logic                  accept, sgn1, sgn2, neg1, neg2, neg_prep, special, fast_mul, q_bit;
  logic [W-1:0]          ext1, ext2, abs1, abs2, min_neg, special_val, rem_nxt, prep_res, fix_res;

  function automatic logic [W-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return W'(s);
  endfunction

  // Sign-correct a double-width value, pick the half the op wants, then apply *W sign extension.
  function automatic logic [W-1:0] pick(input logic [2:0] op, input logic word, input logic neg,
                                        input logic [2*W-1:0] v);
    logic [2*W-1:0] s;
    logic [W-1:0]   r;
    s = neg ? -v : v;
    r = (op == OP_MUL || op[2]) ? s[W-1:0] : s[2*W-1:W];
    return word ? sext32(r[31:0]) : r;
  endfunction

  always_comb begin
    sgn1 = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
    sgn2 = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
    ext1 = src1_q;
    ext2 = src2_q;
    if (word_q) begin
      ext1 = sgn1 ? sext32(src1_q[31:0]) : W'(src1_q[31:0]);
      ext2 = sgn2 ? sext32(src2_q[31:0]) : W'(src2_q[31:0]);
    end
    neg1     = sgn1 & ext1[W-1];
    neg2     = sgn2 & ext2[W-1];
    abs1     = neg1 ? -ext1 : ext1;
    abs2     = neg2 ? -ext2 : ext2;
    neg_prep = (op_q == OP_REM) ? neg1 : (neg1 ^ neg2);
    min_neg  = word_q ? ~W'(32'h7fff_ffff) : {1'b1, {(W-1){1'b0}}};

    special     = 1'b0;
    special_val = '0;
    if (op_q[2] && ext2 == '0) begin
      special     = 1'b1;
      special_val = op_q[1] ? ext1 : '1;
    end else if ((op_q == OP_DIV || op_q == OP_REM) && ext1 == min_neg && ext2 == '1) begin
      special     = 1'b1;
      special_val = op_q[1] ? '0 : ext1;
    end
  end

  assign fix_res  = pick(op_q, word_q, neg_q,
                         op_q[2] ? {{W{1'b0}}, (op_q[1] ? rem_q : quo_q)} : acc_q);
  assign last_cnt = word_q ? CW'(31) : CW'(W - 1);
  assign accept   = i_start & ~i_kill & ((state == IDLE) | (state == DONE));
  assign o_busy   = (state == PREP) || (state == CALC) || (state == FIX);
  assign o_done   = (state == DONE);

`ifdef MULDIV_FAST_MUL_EN
  assign fast_mul = ~op_q[2];
  assign prep_res = special ? pick(op_q, word_q, 1'b0, {{W{1'b0}}, special_val})
                            : pick(op_q, word_q, neg_prep,
                                   {{W{1'b0}}, abs1} * {{W{1'b0}}, abs2});
`else
  assign fast_mul = 1'b0;
  assign prep_res = pick(op_q, word_q, 1'b0, {{W{1'b0}}, special_val});
`endif

  div_step #(.W(W)) u_div_step (
    .rem_cur  (rem_q),
    .shift_bit(quo_q[W-1]),
    .divisor  (dsr_q),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = accept ? PREP : IDLE;
      PREP:       state_nxt = (special || fast_mul) ? DONE : CALC;
      CALC:       if (cnt == last_cnt) state_nxt = FIX;
      FIX:        state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
    if (i_kill) state_nxt = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state     <= IDLE;
      cnt       <= '0;
      o_result  <= '0;
      o_rd_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == PREP) cnt <= '0;
      else if (state == CALC) cnt <= cnt + 1'b1;
      if (state_nxt == DONE) begin
        o_result  <= (state == FIX) ? fix_res : prep_res;
        o_rd_addr <= rd_q;
      end
    end
  end

  // Datapath registers carry no reset; they are always reloaded before being read.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      op_q   <= i_func3;
      word_q <= i_word && (W == 64) && (i_func3 == OP_MUL || i_func3[2]);
      src1_q <= i_src_1;
      src2_q <= i_src_2;
      rd_q   <= i_rd_addr;
    end
    if (state == PREP) begin
      neg_q <= neg_prep;
      acc_q <= '0;
      mcd_q <= {{W{1'b0}}, abs1};
      mpl_q <= abs2;
      rem_q <= '0;
      dsr_q <= abs2;
      quo_q <= word_q ? (abs1 << 32) : abs1;
    end
    if (state == CALC) begin
      if (mpl_q[0]) acc_q <= acc_q + mcd_q;
      mcd_q <= mcd_q << 1;
      mpl_q <= mpl_q >> 1;
      rem_q <= rem_nxt;
      quo_q <= {quo_q[W-2:0], q_bit};
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 64, operand/result width; legal values 32 and 64.
REQ-002 Parameter REG_ADDR_W, default 5, destination register address width.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_srst  input  1  reset, synchronous, active-high.
REQ-005 i_start  input  1  request to begin an operation; sampled only when o_busy is low.
REQ-006 i_func3  input  3  RV M-extension op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 i_word  input  1  RV64 *W variant (MULW/DIVW/DIVUW/REMW/REMUW).
REQ-008 i_src_1  input  DATA_WIDTH  rs1 operand (forwarded value).
REQ-009 i_src_2  input  DATA_WIDTH  rs2 operand (forwarded value).
REQ-010 i_rd_addr  input  REG_ADDR_W  destination register.
REQ-011 i_kill  input  1  flush (branch mispredict/exception); abandons in-flight operation.
REQ-012 o_busy  output  1  operation in flight; drives pipeline stall.
REQ-013 o_done  output  1  one-cycle pulse, o_result/o_rd_addr valid.
REQ-014 o_result  output  DATA_WIDTH  result.
REQ-015 o_rd_addr  output  REG_ADDR_W  destination captured at accept.

Function
REQ-016 FSM states IDLE, PREP, CALC, FIX, DONE; o_busy high in PREP, CALC, FIX; low in IDLE, DONE.
REQ-017 Accept: i_start high, i_kill low, state IDLE or DONE -> operands, func3, word, rd captured; next state PREP.
REQ-018 i_start while o_busy high is ignored; no queueing.
REQ-019 PREP: take absolute values for signed ops, record result sign; N = 32 if i_word else DATA_WIDTH; next CALC with counter 0, unless special case (REQ-022/023) -> DONE.
REQ-020 CALC: one radix-2 iteration per cycle (shift-add multiply, restoring divide); after N iterations (counter N-1) next FIX.
REQ-021 FIX: apply sign correction, select low/high product half or quotient/remainder; next DONE.
REQ-022 Divide by zero: quotient all ones, remainder = dividend; resolved in PREP.
REQ-023 Signed overflow (most-negative / -1): quotient = dividend, remainder 0; resolved in PREP.
REQ-024 Latency accept-edge to o_done: N+3 cycles iterative, 2 cycles special case.
REQ-025 DONE: o_done high exactly one cycle; next IDLE, or PREP if a new start is accepted (back-to-back).
REQ-026 i_word: operands use low 32 bits, result is 32-bit value sign-extended to DATA_WIDTH; i_word ignored for func3 1-3 and when DATA_WIDTH=32.
REQ-027 i_kill high in any state -> IDLE next edge, no o_done; kill beats start in same cycle.
REQ-028 o_result and o_rd_addr hold last value until next DONE.

Reset
REQ-029 i_srst high at an edge -> state IDLE, counter 0, o_busy 0, o_done 0, o_result 0, o_rd_addr 0; overrides i_start and i_kill, including mid-CALC.

Configuration
REQ-030 Macro MULDIV_FAST_MUL_EN defined: multiplies computed in single-cycle multiplier, PREP -> DONE, latency 2; divides unchanged.
REQ-031 Macro undefined: all ops iterative per REQ-020, no hardware multiplier inferred.

Structure
REQ-032 Package muldiv_pkg holds FSM state enum and func3 op localparams.
REQ-033 One sub-module div_step: combinational restoring-divide iteration (partial remainder, divisor -> next remainder, quotient bit).

Verification
REQ-034 DIV 7 / -2, DATA_WIDTH 64 -> result -3, o_done 67 cycles after accept, o_busy high 66 cycles.
REQ-035 REMU 5 / 0 -> 5; DIVU 5 / 0 -> 0xFFFF_FFFF_FFFF_FFFF; both o_done 2 cycles after accept.
REQ-036 DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM same operands -> 0.
REQ-037 MULW 0x7FFF_FFFF * 2 -> 0xFFFF_FFFF_FFFF_FFFE, latency 35; MULHU all-ones * all-ones -> 0xFFFF_FFFF_FFFF_FFFE.
REQ-038 i_kill mid-CALC then start MUL 3*4 same cycle -> no o_done for either; MUL 3*4 next cycle -> 12, rd captured.
REQ-039 i_srst at CALC counter 10 -> all outputs 0 next cycle; start during busy ignored; back-to-back start in DONE accepted.
